// File: rtl/warp_register_file.sv
// Per-warp general-purpose register file for the lane ALUs.
// Storage is organised per lane and indexed by {warp, reg}. Reads are
// registered and can forward a same-edge write. Writes are lane-masked.
// A sequential engine zeroes every register of one warp, one register
// per cycle.
module warp_register_file #(
    parameter  int NUM_LANES  = 8,
    parameter  int DATA_W     = 64,
    parameter  int NUM_REGS   = 64,
    parameter  int NUM_WARPS  = 16,
    parameter  int NUM_RPORTS = 2,
    parameter  int BYPASS     = 1,
    localparam int ADDR_W     = $clog2(NUM_REGS),
    localparam int WARP_W     = $clog2(NUM_WARPS)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_RPORTS*NUM_LANES-1:0]        rd_en,
    input  logic [NUM_RPORTS*WARP_W-1:0]           rd_warp,
    input  logic [NUM_RPORTS*ADDR_W-1:0]           rd_addr,
    output logic [NUM_RPORTS*NUM_LANES*DATA_W-1:0] rd_data,
    output logic [NUM_RPORTS-1:0]                  rd_valid,
    input  logic [NUM_LANES-1:0]                   wr_en,
    input  logic [WARP_W-1:0]                      wr_warp,
    input  logic [ADDR_W-1:0]                      wr_addr,
    input  logic [NUM_LANES*DATA_W-1:0]            wr_data,
    output logic                                  wr_reject,
    input  logic                                  clr_req,
    input  logic [WARP_W-1:0]                      clr_warp,
    output logic                                  clr_busy,
    output logic                                  clr_done
);

    localparam int IDX_W   = WARP_W + ADDR_W;
    localparam int ENTRIES = NUM_WARPS * NUM_REGS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [WARP_W-1:0]   cw_q, cw_d;
    logic                clr_wr;
    logic [IDX_W-1:0]    clr_idx;

    logic [IDX_W-1:0]    wr_idx;
    logic                wr_hit_cw;
    logic [NUM_LANES-1:0] wr_lane_en;
    logic                wr_reject_q, wr_reject_d;

    logic [NUM_RPORTS*NUM_LANES*DATA_W-1:0] rd_data_q, rd_data_d;
    logic [NUM_RPORTS-1:0]                  rd_valid_q, rd_valid_d;
    logic [IDX_W-1:0]                       rd_idx;
    logic [DATA_W-1:0]                      rd_val;

    logic [DATA_W-1:0] mem_q [NUM_LANES][ENTRIES];

    assign clr_idx = {cw_q, ptr_q};
    assign wr_idx  = {wr_warp, wr_addr};

    // A write aimed at the warp being cleared is dropped on every lane so a
    // half-cleared warp never receives fresh data.
    assign wr_hit_cw   = (state_q == S_CLEAR) && (wr_warp == cw_q);
    assign wr_lane_en  = wr_hit_cw ? '0 : wr_en;
    assign wr_reject_d = wr_hit_cw && (|wr_en);

    // Clear engine next-state: latch the target warp, then walk every register.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
        state_d = state_q;
        ptr_d   = ptr_q;
        cw_d    = cw_q;
        clr_wr  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    cw_d    = clr_warp;
                    ptr_d   = '0;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                clr_wr = 1'b1;
                if (ptr_q == ADDR_W'(NUM_REGS - 1)) begin
                    ptr_d   = '0;
                    state_d = S_DONE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Clear engine state, pointer and target warp.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cw_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cw_q    <= cw_d;
        end
    end

    // Storage update: masked lane writes and the clear engine's zeroing write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; it would cost a reset net per bit, and the clear engine zeroes a warp on demand.
        for (int l = 0; l < NUM_LANES; l++) begin
            if (wr_lane_en[l]) begin
                mem_q[l][wr_idx] <= wr_data[l*DATA_W +: DATA_W];
            end
            if (clr_wr) begin
                mem_q[l][clr_idx] <= '0;
            end
        end
    end

    // Read data for every port and lane, with optional same-edge forwarding.
    always_comb begin
        rd_data_d  = '0;
        rd_valid_d = '0;
        rd_idx     = '0;
        rd_val     = '0;
        for (int p = 0; p < NUM_RPORTS; p++) begin
            rd_valid_d[p] = |rd_en[p*NUM_LANES +: NUM_LANES];
            rd_idx        = {rd_warp[p*WARP_W +: WARP_W], rd_addr[p*ADDR_W +: ADDR_W]};
            for (int l = 0; l < NUM_LANES; l++) begin
                rd_val = mem_q[l][rd_idx];
                if (BYPASS != 0) begin
                    if (clr_wr && (rd_idx == clr_idx)) begin
                        rd_val = '0;
                    end
                    if (wr_lane_en[l] && (rd_idx == wr_idx)) begin
                        rd_val = wr_data[l*DATA_W +: DATA_W];
                    end
                end
                if (rd_en[p*NUM_LANES + l]) begin
                    rd_data_d[(p*NUM_LANES + l)*DATA_W +: DATA_W] = rd_val;
                end
            end
        end
    end

    // Registered read outputs and the write-reject pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q   <= '0;
            rd_valid_q  <= '0;
            wr_reject_q <= 1'b0;
        end else begin
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            wr_reject_q <= wr_reject_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign wr_reject = wr_reject_q;
    assign clr_busy  = (state_q == S_CLEAR);
    assign clr_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_warp_register_file.sv
// Directed bench for warp_register_file: a default build (BYPASS=1) and a
// small build (4 lanes, 32 bits, 16 regs, 4 warps, 3 ports, BYPASS=0).
module tb_warp_register_file;

    localparam int AL = 8, AD = 64, AR = 64, AW = 16, AP = 2;
    localparam int BL = 4, BD = 32, BR = 16, BW = 4, BP = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Default build signals
    logic [AP*AL-1:0]    a_rd_en;
    logic [AP*4-1:0]     a_rd_warp;
    logic [AP*6-1:0]     a_rd_addr;
    logic [AP*AL*AD-1:0] a_rd_data;
    logic [AP-1:0]       a_rd_valid;
    logic [AL-1:0]       a_wr_en;
    logic [3:0]          a_wr_warp;
    logic [5:0]          a_wr_addr;
    logic [AL*AD-1:0]    a_wr_data;
    logic                a_wr_reject, a_clr_req, a_clr_busy, a_clr_done;
    logic [3:0]          a_clr_warp;

    // Small build signals
    logic [BP*BL-1:0]    b_rd_en;
    logic [BP*2-1:0]     b_rd_warp;
    logic [BP*4-1:0]     b_rd_addr;
    logic [BP*BL*BD-1:0] b_rd_data;
    logic [BP-1:0]       b_rd_valid;
    logic [BL-1:0]       b_wr_en;
    logic [1:0]          b_wr_warp;
    logic [3:0]          b_wr_addr;
    logic [BL*BD-1:0]    b_wr_data;
    logic                b_wr_reject, b_clr_req, b_clr_busy, b_clr_done;
    logic [1:0]          b_clr_warp;

    logic [AD-1:0] ma [AW][AR][AL];
    logic [BD-1:0] mb [BW][BR][BL];

    warp_register_file dut_a (
        .clk(clk), .rst(rst),
        .rd_en(a_rd_en), .rd_warp(a_rd_warp), .rd_addr(a_rd_addr),
        .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .wr_en(a_wr_en), .wr_warp(a_wr_warp), .wr_addr(a_wr_addr),
        .wr_data(a_wr_data), .wr_reject(a_wr_reject),
        .clr_req(a_clr_req), .clr_warp(a_clr_warp),
        .clr_busy(a_clr_busy), .clr_done(a_clr_done)
    );

    warp_register_file #(
        .NUM_LANES(BL), .DATA_W(BD), .NUM_REGS(BR), .NUM_WARPS(BW),
        .NUM_RPORTS(BP), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst(rst),
        .rd_en(b_rd_en), .rd_warp(b_rd_warp), .rd_addr(b_rd_addr),
        .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .wr_en(b_wr_en), .wr_warp(b_wr_warp), .wr_addr(b_wr_addr),
        .wr_data(b_wr_data), .wr_reject(b_wr_reject),
        .clr_req(b_clr_req), .clr_warp(b_clr_warp),
        .clr_busy(b_clr_busy), .clr_done(b_clr_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AL*AD-1:0] a_rand();
        logic [AL*AD-1:0] v;
        for (int l = 0; l < AL; l++) v[l*AD +: AD] = {$urandom, $urandom} | 64'h1;
        return v;
    endfunction

    function automatic logic [BL*BD-1:0] b_rand();
        logic [BL*BD-1:0] v;
        for (int l = 0; l < BL; l++) v[l*BD +: BD] = $urandom | 32'h1;
        return v;
    endfunction

    task automatic a_write(input int w, input int r, input logic [AL-1:0] m, input logic [AL*AD-1:0] d);
        a_wr_en = m; a_wr_warp = w[3:0]; a_wr_addr = r[5:0]; a_wr_data = d;
        for (int l = 0; l < AL; l++) if (m[l]) ma[w][r][l] = d[l*AD +: AD];
    endtask

    task automatic b_write(input int w, input int r, input logic [BL-1:0] m, input logic [BL*BD-1:0] d);
        b_wr_en = m; b_wr_warp = w[1:0]; b_wr_addr = r[3:0]; b_wr_data = d;
        for (int l = 0; l < BL; l++) if (m[l]) mb[w][r][l] = d[l*BD +: BD];
    endtask

    task automatic a_read(input int p, input int w, input int r, input logic [AL-1:0] m);
        a_rd_en[p*AL +: AL] = m; a_rd_warp[p*4 +: 4] = w[3:0]; a_rd_addr[p*6 +: 6] = r[5:0];
    endtask

    task automatic b_read(input int p, input int w, input int r, input logic [BL-1:0] m);
        b_rd_en[p*BL +: BL] = m; b_rd_warp[p*2 +: 2] = w[1:0]; b_rd_addr[p*4 +: 4] = r[3:0];
    endtask

    function automatic logic [AL*AD-1:0] a_exp(input int w, input int r, input logic [AL-1:0] m);
        logic [AL*AD-1:0] v;
        for (int l = 0; l < AL; l++) v[l*AD +: AD] = m[l] ? ma[w][r][l] : '0;
        return v;
    endfunction

    function automatic logic [BL*BD-1:0] b_exp(input int w, input int r);
        logic [BL*BD-1:0] v;
        for (int l = 0; l < BL; l++) v[l*BD +: BD] = mb[w][r][l];
        return v;
    endfunction

    task automatic a_fill_warp(input int w);
        for (int r = 0; r < AR; r++) begin
            a_write(w, r, '1, a_rand());
            tick();
        end
        a_wr_en = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (a_rd_valid !== 2'b00) begin errors++; $display("FAIL reset_a_valid got=%b want=00", a_rd_valid); end
        checks++; if (a_rd_data !== '0) begin errors++; $display("FAIL reset_a_data got nonzero want=0"); end
        checks++; if ({a_wr_reject, a_clr_busy, a_clr_done} !== 3'b000) begin errors++; $display("FAIL reset_a_flags got=%b want=000", {a_wr_reject, a_clr_busy, a_clr_done}); end
        checks++; if (b_rd_valid !== 3'b000) begin errors++; $display("FAIL reset_b_valid got=%b want=000", b_rd_valid); end
        checks++; if (b_rd_data !== '0) begin errors++; $display("FAIL reset_b_data got nonzero want=0"); end
        checks++; if ({b_wr_reject, b_clr_busy, b_clr_done} !== 3'b000) begin errors++; $display("FAIL reset_b_flags got=%b want=000", {b_wr_reject, b_clr_busy, b_clr_done}); end
        rst = 1'b0;
    endtask

    task automatic test_defaults_a();
        for (int w = 0; w < AW; w++) a_fill_warp(w);
        for (int i = 0; i < AW*AR; i++) begin
            a_read(0, i / AR, i % AR, '1);
            a_read(1, AW - 1 - i / AR, AR - 1 - i % AR, '1);
            tick();
            checks++; if (a_rd_data[0 +: AL*AD] !== a_exp(i / AR, i % AR, '1)) begin errors++; $display("FAIL defaults_a_p0 w=%0d r=%0d got=%h want=%h", i / AR, i % AR, a_rd_data[0 +: AL*AD], a_exp(i / AR, i % AR, '1)); end
            checks++; if (a_rd_data[AL*AD +: AL*AD] !== a_exp(AW - 1 - i / AR, AR - 1 - i % AR, '1)) begin errors++; $display("FAIL defaults_a_p1 i=%0d got=%h want=%h", i, a_rd_data[AL*AD +: AL*AD], a_exp(AW - 1 - i / AR, AR - 1 - i % AR, '1)); end
            checks++; if (a_rd_valid !== 2'b11) begin errors++; $display("FAIL defaults_a_valid i=%0d got=%b want=11", i, a_rd_valid); end
        end
        a_read(0, 1, 2, '1);
        a_read(1, 0, 0, '0);
        tick();
        checks++; if (a_rd_valid !== 2'b01) begin errors++; $display("FAIL port0_only_valid got=%b want=01", a_rd_valid); end
        checks++; if (a_rd_data[AL*AD +: AL*AD] !== '0) begin errors++; $display("FAIL port0_only_p1 got=%h want=0", a_rd_data[AL*AD +: AL*AD]); end
        a_read(0, 0, 0, '0);
        a_read(1, 1, 2, '1);
        tick();
        checks++; if (a_rd_valid !== 2'b10) begin errors++; $display("FAIL port1_only_valid got=%b want=10", a_rd_valid); end
        checks++; if (a_rd_data[AL*AD +: AL*AD] !== a_exp(1, 2, '1)) begin errors++; $display("FAIL port1_only_p1 got=%h want=%h", a_rd_data[AL*AD +: AL*AD], a_exp(1, 2, '1)); end
        a_rd_en = '0;
        tick();
        checks++; if (a_rd_valid !== 2'b00) begin errors++; $display("FAIL idle_valid got=%b want=00", a_rd_valid); end
    endtask

    task automatic test_lane_mask_a();
        a_write(3, 7, '1, {8{64'hAAAA_AAAA_AAAA_AAAA}});
        tick();
        a_write(3, 7, 8'h0F, {8{64'h5555_5555_5555_5555}});
        tick();
        a_wr_en = '0;
        a_read(0, 3, 7, '1);
        a_read(1, 3, 7, 8'hF0);
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== {{4{64'hAAAA_AAAA_AAAA_AAAA}}, {4{64'h5555_5555_5555_5555}}}) begin errors++; $display("FAIL lane_mask_p0 got=%h", a_rd_data[0 +: AL*AD]); end
        checks++; if (a_rd_data[AL*AD +: AL*AD] !== {{4{64'hAAAA_AAAA_AAAA_AAAA}}, 256'h0}) begin errors++; $display("FAIL lane_mask_p1_hi got=%h", a_rd_data[AL*AD +: AL*AD]); end
        a_read(0, 3, 7, 8'h01);
        a_read(1, 3, 7, 8'h00);
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== {448'h0, 64'h5555_5555_5555_5555}) begin errors++; $display("FAIL lane_mask_rden01 got=%h", a_rd_data[0 +: AL*AD]); end
        checks++; if (a_rd_valid !== 2'b01) begin errors++; $display("FAIL lane_mask_valid got=%b want=01", a_rd_valid); end
        a_rd_en = '0;
    endtask

    task automatic test_collision_a();
        a_write(2, 5, '1, {8{64'hFFFF}});
        tick();
        a_write(2, 5, '1, {8{64'h1234}});
        a_read(0, 2, 5, '1);
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== {8{64'h1234}}) begin errors++; $display("FAIL collision_a_bypass got=%h want=1234s", a_rd_data[0 +: AL*AD]); end
        a_write(2, 5, 8'h01, {8{64'h99}});
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== {{7{64'h1234}}, 64'h99}) begin errors++; $display("FAIL collision_a_lane got=%h", a_rd_data[0 +: AL*AD]); end
        a_wr_en = '0;
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== {{7{64'h1234}}, 64'h99}) begin errors++; $display("FAIL collision_a_stored got=%h", a_rd_data[0 +: AL*AD]); end
        a_rd_en = '0;
    endtask

    task automatic test_collision_b();
        b_write(2, 5, '1, {4{32'hFFFF}});
        tick();
        b_write(2, 5, '1, {4{32'h1234}});
        b_read(0, 2, 5, '1);
        tick();
        checks++; if (b_rd_data[0 +: BL*BD] !== {4{32'hFFFF}}) begin errors++; $display("FAIL collision_b_old got=%h want=FFFFs", b_rd_data[0 +: BL*BD]); end
        b_write(2, 5, 4'h1, {4{32'h99}});
        tick();
        checks++; if (b_rd_data[0 +: BL*BD] !== {4{32'h1234}}) begin errors++; $display("FAIL collision_b_lane got=%h want=1234s", b_rd_data[0 +: BL*BD]); end
        b_wr_en = '0;
        tick();
        checks++; if (b_rd_data[0 +: BL*BD] !== {{3{32'h1234}}, 32'h99}) begin errors++; $display("FAIL collision_b_stored got=%h", b_rd_data[0 +: BL*BD]); end
        b_rd_en = '0;
    endtask

    task automatic test_clear_a();
        int busy_cnt;
        busy_cnt = 0;
        a_clr_req = 1'b1; a_clr_warp = 4'd4;
        tick();
        a_clr_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!a_clr_busy) break;
            busy_cnt++;
            tick();
        end
        checks++; if (busy_cnt != AR) begin errors++; $display("FAIL clear_a_busy_len got=%0d want=%0d", busy_cnt, AR); end
        checks++; if (a_clr_done !== 1'b1) begin errors++; $display("FAIL clear_a_done got=%b want=1", a_clr_done); end
        tick();
        checks++; if ({a_clr_done, a_clr_busy} !== 2'b00) begin errors++; $display("FAIL clear_a_after got=%b want=00", {a_clr_done, a_clr_busy}); end
        for (int r = 0; r < AR; r++) for (int l = 0; l < AL; l++) ma[4][r][l] = '0;
        for (int r = 0; r < AR; r++) begin
            a_read(0, 4, r, '1);
            a_read(1, 5, r, '1);
            tick();
            checks++; if (a_rd_data[0 +: AL*AD] !== '0) begin errors++; $display("FAIL clear_a_w4 r=%0d got=%h want=0", r, a_rd_data[0 +: AL*AD]); end
            checks++; if (a_rd_data[AL*AD +: AL*AD] !== a_exp(5, r, '1)) begin errors++; $display("FAIL clear_a_w5 r=%0d got=%h want=%h", r, a_rd_data[AL*AD +: AL*AD], a_exp(5, r, '1)); end
        end
        a_rd_en = '0;
    endtask

    task automatic test_clear_conflicts_a();
        int busy_cnt;
        int extra;
        logic [AL*AD-1:0] w63;
        busy_cnt = 0;
        extra = 0;
        a_fill_warp(4);
        w63 = a_exp(4, 63, '1);
        a_clr_req = 1'b1; a_clr_warp = 4'd4;
        tick();
        a_clr_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!a_clr_busy) break;
            busy_cnt++;
            if (i == 21) begin
                checks++; if (a_wr_reject !== 1'b1) begin errors++; $display("FAIL conflict_reject got=%b want=1", a_wr_reject); end
            end
            if (i == 22) begin
                checks++; if (a_wr_reject !== 1'b0) begin errors++; $display("FAIL conflict_other_warp_reject got=%b want=0", a_wr_reject); end
            end
            if (i == 41) begin
                checks++; if (a_rd_data[0 +: AL*AD] !== '0) begin errors++; $display("FAIL conflict_read_ptr got=%h want=0", a_rd_data[0 +: AL*AD]); end
                checks++; if (a_rd_data[AL*AD +: AL*AD] !== w63) begin errors++; $display("FAIL conflict_read_uncleared got=%h want=%h", a_rd_data[AL*AD +: AL*AD], w63); end
            end
            a_wr_en = '0; a_rd_en = '0; a_clr_req = 1'b0;
            if (i == 20) begin
                a_wr_en = '1; a_wr_warp = 4'd4; a_wr_addr = 6'd63; a_wr_data = {8{64'hDEAD}};
            end
            if (i == 21) a_write(9, 1, '1, {8{64'h9191}});
            if (i == 30) begin a_clr_req = 1'b1; a_clr_warp = 4'd5; end
            if (i == 40) begin
                a_read(0, 4, 40, '1);
                a_read(1, 4, 63, '1);
            end
            tick();
        end
        a_wr_en = '0; a_rd_en = '0; a_clr_req = 1'b0;
        checks++; if (busy_cnt != AR) begin errors++; $display("FAIL conflict_busy_len got=%0d want=%0d", busy_cnt, AR); end
        checks++; if (a_clr_done !== 1'b1) begin errors++; $display("FAIL conflict_done got=%b want=1", a_clr_done); end
        for (int k = 0; k < 8; k++) begin
            tick();
            if (a_clr_done || a_clr_busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL conflict_requeued got=%0d busy/done cycles want=0", extra); end
        for (int r = 0; r < AR; r++) for (int l = 0; l < AL; l++) ma[4][r][l] = '0;
        a_read(0, 4, 63, '1);
        a_read(1, 9, 1, '1);
        tick();
        checks++; if (a_rd_data[0 +: AL*AD] !== '0) begin errors++; $display("FAIL conflict_r63 got=%h want=0", a_rd_data[0 +: AL*AD]); end
        checks++; if (a_rd_data[AL*AD +: AL*AD] !== {8{64'h9191}}) begin errors++; $display("FAIL conflict_w9 got=%h want=9191s", a_rd_data[AL*AD +: AL*AD]); end
        a_rd_en = '0;
    endtask

    task automatic test_reset_mid_clear_a();
        int n;
        int extra;
        n = 0;
        extra = 0;
        a_fill_warp(4);
        a_clr_req = 1'b1; a_clr_warp = 4'd4;
        tick();
        a_clr_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!a_clr_busy) break;
            n++;
            if (n == 10) break;
            tick();
        end
        checks++; if (n != 10) begin errors++; $display("FAIL midreset_busy_cycles got=%0d want=10", n); end
        rst = 1'b1;
        tick();
        checks++; if ({a_clr_busy, a_clr_done} !== 2'b00) begin errors++; $display("FAIL midreset_flags got=%b want=00", {a_clr_busy, a_clr_done}); end
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (a_clr_done || a_clr_busy) extra++;
        end
        checks++; if (extra != 0) begin errors++; $display("FAIL midreset_late_done got=%0d want=0", extra); end
        for (int r = 0; r < 10; r++) for (int l = 0; l < AL; l++) ma[4][r][l] = '0;
        for (int r = 0; r < AR; r++) begin
            a_read(0, 4, r, '1);
            tick();
            checks++; if (a_rd_data[0 +: AL*AD] !== a_exp(4, r, '1)) begin errors++; $display("FAIL midreset_w4 r=%0d got=%h want=%h", r, a_rd_data[0 +: AL*AD], a_exp(4, r, '1)); end
        end
        a_rd_en = '0;
    endtask

    task automatic test_defaults_b();
        for (int i = 0; i < BW*BR; i++) begin
            b_write(i / BR, i % BR, '1, b_rand());
            tick();
        end
        b_wr_en = '0;
        for (int i = 0; i < BW*BR; i++) begin
            for (int p = 0; p < BP; p++) b_read(p, ((i + p*21) % 64) / BR, ((i + p*21) % 64) % BR, '1);
            tick();
            for (int p = 0; p < BP; p++) begin
                checks++; if (b_rd_data[p*BL*BD +: BL*BD] !== b_exp(((i + p*21) % 64) / BR, ((i + p*21) % 64) % BR)) begin errors++; $display("FAIL defaults_b p=%0d i=%0d got=%h", p, i, b_rd_data[p*BL*BD +: BL*BD]); end
            end
            checks++; if (b_rd_valid !== 3'b111) begin errors++; $display("FAIL defaults_b_valid i=%0d got=%b want=111", i, b_rd_valid); end
        end
        b_rd_en = '0;
    endtask

    task automatic test_clear_b();
        int busy_cnt;
        busy_cnt = 0;
        b_clr_req = 1'b1; b_clr_warp = 2'd1;
        tick();
        b_clr_req = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!b_clr_busy) break;
            busy_cnt++;
            tick();
        end
        checks++; if (busy_cnt != BR) begin errors++; $display("FAIL clear_b_busy_len got=%0d want=%0d", busy_cnt, BR); end
        checks++; if (b_clr_done !== 1'b1) begin errors++; $display("FAIL clear_b_done got=%b want=1", b_clr_done); end
        tick();
        checks++; if (b_clr_done !== 1'b0) begin errors++; $display("FAIL clear_b_done_pulse got=%b want=0", b_clr_done); end
        for (int r = 0; r < BR; r++) begin
            b_read(0, 1, r, '1);
            b_read(1, 2, r, '1);
            b_read(2, 0, r, '1);
            tick();
            checks++; if (b_rd_data[0 +: BL*BD] !== '0) begin errors++; $display("FAIL clear_b_w1 r=%0d got=%h want=0", r, b_rd_data[0 +: BL*BD]); end
            checks++; if (b_rd_data[BL*BD +: BL*BD] !== b_exp(2, r)) begin errors++; $display("FAIL clear_b_w2 r=%0d got=%h want=%h", r, b_rd_data[BL*BD +: BL*BD], b_exp(2, r)); end
            checks++; if (b_rd_data[2*BL*BD +: BL*BD] !== b_exp(0, r)) begin errors++; $display("FAIL clear_b_w0 r=%0d got=%h want=%h", r, b_rd_data[2*BL*BD +: BL*BD], b_exp(0, r)); end
        end
        b_rd_en = '0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        a_rd_en = '0; a_rd_warp = '0; a_rd_addr = '0; a_wr_en = '0; a_wr_warp = '0;
        a_wr_addr = '0; a_wr_data = '0; a_clr_req = 1'b0; a_clr_warp = '0;
        b_rd_en = '0; b_rd_warp = '0; b_rd_addr = '0; b_wr_en = '0; b_wr_warp = '0;
        b_wr_addr = '0; b_wr_data = '0; b_clr_req = 1'b0; b_clr_warp = '0;
        test_reset();
        test_defaults_a();
        test_lane_mask_a();
        test_collision_a();
        test_collision_b();
        test_clear_a();
        test_clear_conflicts_a();
        test_reset_mid_clear_a();
        test_defaults_b();
        test_clear_b();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
